// File: rtl/fill_arbiter.sv
// fill_arbiter: round-robin packet arbiter with per-beat fill modes onto one registered channel
// Ports: req_valid/req_last/req_mode/req_data/req_ready are the per-requester beat inputs and grant;
// out_valid/out_data/out_last/out_id/out_ready form the registered output channel; clk, rst_n (sync, active-low).
module fill_arbiter #(
    parameter int WIDTH  = 64,
    parameter int NREQ   = 4,
    parameter int NARROW = 3,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [2*NREQ-1:0]     req_mode,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [IW-1:0]         out_id,
    input  logic                  out_ready
);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d, rr_q, rr_d, out_id_q, out_id_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [NREQ-1:0]   rot;
    logic [IW:0]       sum;
    logic [IW-1:0]     cand, winner;
    logic              found, win_valid, accept, win_last;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  data, fill;
    always_comb begin
        // requests rotated so bit 0 is rr_q; lowest set bit is the round-robin candidate
        rot   = NREQ'({req_valid, req_valid} >> rr_q);
        found = 1'b0;
        sum   = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_q} + (IW+1)'(k);
            end
        end
        cand        = IW'(sum >= (IW+1)'(NREQ) ? sum - (IW+1)'(NREQ) : sum);
        winner      = (state_q == OWNED) ? owner_q : cand;
        win_valid   = (state_q == OWNED) ? req_valid[winner] : found;
        win_last    = req_last[winner];
        accept      = rst_n && (!out_valid_q || out_ready) && win_valid;
        req_ready   = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;
        mode        = 2'(req_mode >> {winner, 1'b0});
        data        = WIDTH'(req_data >> (winner * WIDTH));
        fill        = mode == 2'b00 ? '0 :
                      mode == 2'b01 ? '1 :
                      mode == 2'b10 ? data :
                      {{(WIDTH-NARROW){1'b0}}, data[NARROW-1:0]};
        state_d     = accept ? (win_last ? IDLE : OWNED) : state_q;
        owner_d     = accept ? winner : owner_q;
        rr_d        = (accept && win_last) ? (winner == IW'(NREQ-1) ? '0 : winner + 1'b1) : rr_q;
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = accept ? fill : out_data_q;
        out_last_d  = accept ? win_last : out_last_q;
        out_id_d    = accept ? winner : out_id_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;
endmodule

// File: tb/tb_fill_arbiter.sv
// tb_fill_arbiter: randomized scoreboard bench for fill_arbiter against a packet-level reference model
module tb_fill_arbiter;
    localparam int W = 64, N = 4, NARROW = 3;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_last, req_ready;
    logic [2*N-1:0]   req_mode;
    logic [W*N-1:0]   req_data;
    logic             out_valid, out_last, out_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       out_id;
    fill_arbiter #(.WIDTH(W), .NREQ(N), .NARROW(NARROW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_mode(req_mode), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_id(out_id), .out_ready(out_ready)
    );
    always #5 clk = ~clk;
    typedef struct { logic [W-1:0] d; logic [1:0] m; logic l; } beat_t;
    typedef struct { logic [W-1:0] d; logic l; int id; } exp_t;
    beat_t rq[N][$];
    exp_t  sb[$];
    int    tests = 0, errors = 0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [W-1:0] fill_of(input logic [1:0] m, input logic [W-1:0] d);
        case (m)
            2'd0:    return '0;
            2'd1:    return ~64'd0;
            2'd2:    return d;
            default: return d & ((64'd1 << NARROW) - 64'd1);
        endcase
    endfunction
    // monitor: a beat retires at the next edge when valid and ready are both high
    logic          hold_p = 1'b0;
    logic [W-1:0]  hd;
    logic          hl;
    logic [1:0]    hid;
    always @(negedge clk) begin
        if (!rst_n) hold_p <= 1'b0;
        else begin
            if (hold_p) begin
                chk("hold_data", out_data, hd);
                chk("hold_last", 64'(out_last), 64'(hl));
                chk("hold_id", 64'(out_id), 64'(hid));
            end
            hold_p <= out_valid && !out_ready;
            hd <= out_data; hl <= out_last; hid <= out_id;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_id), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", 64'(out_last), 64'(e.l));
                    chk("out_id", 64'(out_id), 64'(e.id));
                end
            end
        end
    end
    initial begin
        int  owner = -1, rr = 0, cyc = 0, d_w = 0, w, len;
        bit  ov = 0, d_rst = 0, d_acc = 0, d_last = 0, d_ready = 0, ok;
        logic [N-1:0] exp_rdy;
        beat_t b;
        for (int m = 0; m < 4; m++) begin
            b.d = 64'hDEAD_BEEF_0123_4567; b.m = 2'(m); b.l = 1'b1; rq[0].push_back(b);
        end
        b.d = 64'hFFFF_FFFF_FFFF_FFF8; b.m = 2'd3; b.l = 1'b1; rq[0].push_back(b);
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 20; p++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b.d = {$urandom, $urandom}; b.m = 2'($urandom_range(0, 3)); b.l = (k == len - 1);
                    rq[i].push_back(b);
                end
            end
        rst_n = 1'b0; out_ready = 1'b0; req_valid = '0; req_last = '0; req_mode = '0; req_data = '0;
        repeat (2) @(posedge clk);
        while (cyc < 4000 && (d_rst == 0 || ov || sb.size() != 0 || rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() != 0)) begin
            @(posedge clk);
            cyc++;
            if (!d_rst) begin
                ov = 0; owner = -1; rr = 0; sb.delete();
            end else if (d_acc) begin
                ov = 1;
                if (d_last) begin owner = -1; rr = (d_w + 1) % N; end
                else owner = d_w;
            end else if (ov && d_ready) ov = 0;
            #2;
            rst_n = !(cyc == 150);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = rq[i].size() != 0 && $urandom_range(0, 3) != 0;
                if (rq[i].size() != 0) begin
                    req_data[W*i +: W] = rq[i][0].d; req_mode[2*i +: 2] = rq[i][0].m; req_last[i] = rq[i][0].l;
                end else begin
                    req_data[W*i +: W] = {$urandom, $urandom}; req_mode[2*i +: 2] = 2'($urandom); req_last[i] = 1'($urandom);
                end
            end
            #1;
            chk("out_valid", 64'(out_valid), 64'(ov));
            if (!d_rst) begin
                chk("rst_data", out_data, 64'd0);
                chk("rst_last", 64'(out_last), 64'd0);
                chk("rst_id", 64'(out_id), 64'd0);
            end
            w = -1;
            if (owner >= 0) begin
                if (req_valid[owner]) w = owner;
            end else
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(rr + k) % N]) w = (rr + k) % N;
            ok = rst_n && (!ov || out_ready) && w >= 0;
            exp_rdy = '0;
            if (ok) exp_rdy[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            d_rst = rst_n; d_acc = ok; d_ready = out_ready;
            if (ok) begin
                b = rq[w].pop_front();
                d_w = w; d_last = b.l;
                sb.push_back('{d: fill_of(b.m, b.d), l: b.l, id: w});
            end
        end
        if (cyc >= 4000) chk("timeout", 64'(cyc), 64'd0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
